stream_read_sequencer: RTL and testbench

STREAM_READ_SEQUENCER -- requirements
Module: stream_read_sequencer

---
 rtl/stream_read_sequencer.sv | 131 +++++++++++++
 tb/tb_stream_read_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_read_sequencer.sv
// Issues a job's read addresses in order, throttled by outstanding returns and,
// when STREAM_READ_SEQUENCER_HAZARD_EN is defined, by a write-address watermark.
module stream_read_sequencer #(
  parameter int addrN   = 8,
  parameter int MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [addrN-1:0] start_base,
  input  logic [addrN:0]   start_len,
  input  logic             wr_fire,
  input  logic [addrN-1:0] wr_addr,
  output logic [addrN-1:0] ra,
  output logic             ra_valid,
  input  logic             ra_ready,
  input  logic             rd_fire,
  output logic             done,
  output logic             err
);
  localparam int              OW      = $clog2(MAX_OUT + 1);
  localparam logic [OW-1:0]    OUT_MAX = OW'(MAX_OUT);
  localparam logic [OW-1:0]    ONE_O   = OW'(1);
  localparam logic [addrN-1:0] ONE_A   = addrN'(1);
  localparam logic [addrN:0]   ONE_L   = (addrN+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;

  logic [addrN-1:0] cur, cur_inc, ra_n;
  logic [addrN:0]   rem;
  logic [OW-1:0]    outst, outst_n;
  logic             ra_fire, underflow, issue_ok, gate_cur, gate_inc, load, ra_valid_n;

  assign ra_fire     = ra_valid && ra_ready;
  assign cur_inc     = cur + ONE_A;
  assign start_ready = (state == IDLE);
  assign done        = (state == DONE);

`ifdef STREAM_READ_SEQUENCER_HAZARD_EN
  // wm is one past the highest written address; one extra bit so address
  // 2^addrN-1 written yields a watermark that still compares above it.
  logic [addrN:0] wm, wm_cand;
  assign wm_cand = {1'b0, wr_addr} + ONE_L;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) wm <= '0;
    else if (wr_fire && (wm_cand > wm)) wm <= wm_cand;
  end

  assign gate_cur = ({1'b0, cur} < wm);
  assign gate_inc = ({1'b0, cur_inc} < wm);
`else
  logic unused_wr;
  assign unused_wr = ^{wr_fire, wr_addr};
  assign gate_cur  = 1'b1;
  assign gate_inc  = 1'b1;
`endif

  // Issue decisions look at the post-edge count so a return frees a slot
  // in the same edge it arrives.
  always_comb begin
    outst_n   = outst;
    underflow = 1'b0;
    if (ra_fire && !rd_fire) outst_n = outst + ONE_O;
    else if (rd_fire && !ra_fire) begin
      if (outst == '0) underflow = 1'b1;
      else             outst_n   = outst - ONE_O;
    end
  end

  assign issue_ok = (outst_n < OUT_MAX);

  always_comb begin
    state_n    = state;
    load       = 1'b0;
    ra_valid_n = ra_valid;
    ra_n       = ra;
    case (state)
      IDLE: if (start_valid) begin
        load    = 1'b1;
        state_n = (start_len == '0) ? DONE : RUN;
      end
      RUN: begin
        if (ra_fire) begin
          if (rem == ONE_L) begin
            state_n    = DRAIN;
            ra_valid_n = 1'b0;
          end else if (issue_ok && gate_inc) ra_n = cur_inc;
          else ra_valid_n = 1'b0;
        end else if (!ra_valid && issue_ok && gate_cur) begin
          ra_valid_n = 1'b1;
          ra_n       = cur;
        end
      end
      DRAIN: if (outst_n == '0) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cur      <= '0;
      rem      <= '0;
      outst    <= '0;
      ra       <= '0;
      ra_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      ra       <= ra_n;
      ra_valid <= ra_valid_n;
      outst    <= outst_n;
      if (underflow) err <= 1'b1;
      if (load) begin
        cur <= start_base;
        rem <= start_len;
      end else if (state == RUN && ra_fire) begin
        cur <= cur_inc;
        rem <= rem - ONE_L;
      end
    end
  end

endmodule

// File: tb/tb_stream_read_sequencer.sv
// Directed bench for stream_read_sequencer: fixed jobs with hand-computed
// address sequences, issue cycles and done timing.
module tb_stream_read_sequencer;
  localparam int AW = 8;

  logic          clk, nrst;
  logic          start_valid, start_ready;
  logic [AW-1:0] start_base;
  logic [AW:0]   start_len;
  logic          wr_fire;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] ra;
  logic          ra_valid, ra_ready;
  logic          rd_fire, done, err;

  logic          auto_rd, man_rd;
  logic [1:0]    hist = '0;
  int            cyc = 0;
  int            done_cnt = 0;
  int            nvec, nmis;
  int            fq[$];
  int            fc[$];
  int            h, at, d0;

  stream_read_sequencer #(.addrN(AW), .MAX_OUT(4)) dut (
    .clk(clk), .nrst(nrst),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_base(start_base), .start_len(start_len),
    .wr_fire(wr_fire), .wr_addr(wr_addr),
    .ra(ra), .ra_valid(ra_valid), .ra_ready(ra_ready),
    .rd_fire(rd_fire), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns arrive exactly two edges after each address handshake when auto_rd.
  assign rd_fire = auto_rd ? hist[1] : man_rd;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    hist <= {hist[0], ra_valid && ra_ready};
    if (ra_valid && ra_ready) begin
      fq.push_back(int'(ra));
      fc.push_back(cyc);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_job(input string tag, input int base, input int len, output int hs);
    chk({tag, "_start_rdy"}, start_ready, 1);
    start_base  = AW'(base);
    start_len   = (AW+1)'(len);
    start_valid = 1'b1;
    tick(1);
    hs = cyc - 1;
    start_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int when);
    when = -1;
    for (int i = 0; i < budget && when < 0; i++) begin
      tick(1);
      if (done) when = cyc;
    end
    chk({tag, "_done_seen"}, (when >= 0), 1);
  endtask

  task automatic open_gate();
    wr_addr = 8'd255;
    wr_fire = 1'b1;
    tick(1);
    wr_fire = 1'b0;
  endtask

  initial begin
    int w[3];
    nvec = 0; nmis = 0;
    nrst = 1'b0; start_valid = 1'b0; start_base = '0; start_len = '0;
    wr_fire = 1'b0; wr_addr = '0; ra_ready = 1'b1; auto_rd = 1'b0; man_rd = 1'b0;
    #12;
    chk("rst_ra_valid", ra_valid, 0);
    chk("rst_ra", ra, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk); nrst = 1'b1;
    tick(1);
    chk("rst_start_rdy", start_ready, 1);

`ifdef STREAM_READ_SEQUENCER_HAZARD_EN
    // Watermark starts at 0: nothing may issue until the matching write lands.
    auto_rd = 1'b1; fq.delete(); fc.delete();
    start_job("hz", 0, 3, h);
    tick(2);
    chk("hz_blocked_n", fq.size(), 0);
    chk("hz_blocked_vld", ra_valid, 0);
    for (int k = 0; k < 3; k++) begin
      wr_addr = AW'(k);
      wr_fire = 1'b1;
      tick(1);
      w[k] = cyc - 1;
      wr_fire = 1'b0;
      tick(2);
    end
    wait_done("hz", 20, at);
    chk("hz_n", fq.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hz_ra%0d", k), fq[k], k);
      chk($sformatf("hz_cyc%0d", k), fc[k], w[k] + 2);
    end
    tick(1);
`endif
    open_gate();

    // Back-to-back job with returns two cycles behind.
    auto_rd = 1'b1; fq.delete(); fc.delete(); d0 = done_cnt;
    start_job("a", 0, 5, h);
    wait_done("a", 40, at);
    chk("a_done_cyc", at, h + 9);
    chk("a_n", fq.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("a_ra%0d", i), fq[i], i);
      chk($sformatf("a_cyc%0d", i), fc[i], h + 2 + i);
    end
    tick(1);
    chk("a_rdy_back", start_ready, 1);
    chk("a_done_once", done_cnt - d0, 1);
    chk("a_err", err, 0);

    // Outstanding limit: four issues, then stall until a return.
    auto_rd = 1'b0; man_rd = 1'b0; fq.delete(); fc.delete(); d0 = done_cnt;
    start_job("b", 0, 8, h);
    tick(10);
    chk("b_n_stall", fq.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("b_ra%0d", i), fq[i], i);
    chk("b_vld_lo", ra_valid, 0);
    man_rd = 1'b1;
    tick(1);
    chk("b_vld_after_rd", ra_valid, 1);
    chk("b_ra_after_rd", ra, 4);
    tick(7);
    chk("b_done", done, 1);
    man_rd = 1'b0;
    tick(1);
    chk("b_n_all", fq.size(), 8);
    for (int i = 4; i < 8; i++) chk($sformatf("b_ra%0d", i), fq[i], i);
    chk("b_done_once", done_cnt - d0, 1);
    chk("b_err", err, 0);

    // Address wrap.
    auto_rd = 1'b1; fq.delete(); fc.delete(); d0 = done_cnt;
    start_job("c", 254, 4, h);
    wait_done("c", 30, at);
    chk("c_done_cyc", at, h + 8);
    chk("c_n", fq.size(), 4);
    chk("c_ra0", fq[0], 254);
    chk("c_ra1", fq[1], 255);
    chk("c_ra2", fq[2], 0);
    chk("c_ra3", fq[3], 1);
    tick(1);
    chk("c_done_once", done_cnt - d0, 1);
    chk("c_err", err, 0);

    // Empty job.
    fq.delete(); fc.delete(); d0 = done_cnt;
    start_job("d", 7, 0, h);
    chk("d_done", done, 1);
    chk("d_vld", ra_valid, 0);
    chk("d_rdy_lo", start_ready, 0);
    tick(1);
    chk("d_done_lo", done, 0);
    chk("d_rdy_back", start_ready, 1);
    chk("d_done_once", done_cnt - d0, 1);
    chk("d_no_ra", fq.size(), 0);

    // Reset mid-job with three reads outstanding.
    auto_rd = 1'b0; fq.delete(); fc.delete();
    start_job("e", 0, 8, h);
    tick(4);
    chk("e_n_pre", fq.size(), 3);
    chk("e_vld_pre", ra_valid, 1);
    #2; nrst = 1'b0; #1;
    chk("e_rst_vld", ra_valid, 0);
    chk("e_rst_ra", ra, 0);
    chk("e_rst_done", done, 0);
    chk("e_rst_err", err, 0);
    chk("e_rst_rdy", start_ready, 1);
    d0 = done_cnt;
    tick(3);
    @(negedge clk); nrst = 1'b1;
    tick(1);
    chk("e_rdy_after", start_ready, 1);
    chk("e_no_done", done_cnt - d0, 0);
    open_gate();
    auto_rd = 1'b1; fq.delete(); fc.delete(); d0 = done_cnt;
    start_job("e2", 0, 2, h);
    wait_done("e2", 30, at);
    chk("e2_done_cyc", at, h + 6);
    chk("e2_n", fq.size(), 2);
    chk("e2_ra0", fq[0], 0);
    chk("e2_ra1", fq[1], 1);
    tick(1);
    chk("e2_done_once", done_cnt - d0, 1);
    chk("e2_err", err, 0);

    // Stray return with nothing outstanding sets the sticky error.
    auto_rd = 1'b0; man_rd = 1'b1;
    tick(1);
    man_rd = 1'b0;
    chk("f_err_set", err, 1);
    tick(2);
    chk("f_err_sticky", err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
